// File: rtl/cpu_pkg.sv
// cpu_pkg -- constants and types shared by the 8-bit pipelined CPU stages
// (ID stage, EX/WB pipeline register, writeback/register file).
//   DATA_W    : register and datapath width
//   ADDR_W    : register address width (2**ADDR_W architectural registers)
//   NOP_INSTR : bubble encoding; never counted as a retired instruction
package cpu_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned NUM_REGS  = 2 ** ADDR_W;
  localparam logic [7:0]  NOP_INSTR = 8'h00;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage : cpu_pkg

// File: rtl/regfile_core.sv
// regfile_core -- NUM_REGS x DATA_W architectural storage.
// Ports:
//   clk, rst              : clock, synchronous active-high reset (clears all)
//   we, waddr, wdata      : single write port, committed on the rising edge
//   raddr1/rdata1         : combinational read port 1 (no bypass)
//   raddr2/rdata2         : combinational read port 2 (no bypass)
//   dbg_addr/dbg_rdata    : combinational debug read port (no bypass)
module regfile_core
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      we,
  input  reg_addr_t waddr,
  input  reg_data_t wdata,
  input  reg_addr_t raddr1,
  input  reg_addr_t raddr2,
  input  reg_addr_t dbg_addr,
  output reg_data_t rdata1,
  output reg_data_t rdata2,
  output reg_data_t dbg_rdata
);

  reg_data_t mem_q [NUM_REGS];
  reg_data_t mem_d [NUM_REGS];

  // Next-state of every register: reset wins over the write port.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst) begin
        mem_d[i] = '0;
      end else if (we && (waddr == reg_addr_t'(i))) begin
        mem_d[i] = wdata;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  // Storage flops.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata1    = mem_q[raddr1];
  assign rdata2    = mem_q[raddr2];
  assign dbg_rdata = mem_q[dbg_addr];

endmodule : regfile_core

// File: rtl/wb_regfile.sv
// wb_regfile -- writeback stage plus architectural register file.
// Selects the write-back value, commits it, serves two bypassed decode read
// ports and one architectural debug port, and tracks retired instructions.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   WB_regwrite, WB_ImmLoad     : write enable, immediate-vs-ALU select
//   WB_ALUres, WB_ImmData       : candidate write-back values
//   WB_writereg, WB_instr       : destination register, instruction in WB
//   rd_addr1/rd_data1           : decode read port 1 (WB bypass)
//   rd_addr2/rd_data2           : decode read port 2 (WB bypass)
//   dbg_addr/dbg_data           : debug read port (architectural state only)
//   wb_wdata                    : selected write-back value (combinational)
//   retired_count, last_instr   : retire counter and last non-NOP retired
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_regwrite,
  input  logic              WB_ImmLoad,
  input  logic [DATA_W-1:0] WB_ALUres,
  input  logic [DATA_W-1:0] WB_ImmData,
  input  logic [ADDR_W-1:0] WB_writereg,
  input  logic [7:0]        WB_instr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [CNT_W-1:0]  retired_count,
  output logic [7:0]        last_instr
);

  reg_data_t          core_rdata1_s;
  reg_data_t          core_rdata2_s;
  logic               retire_s;
  logic [CNT_W-1:0]   retired_count_d, retired_count_q;
  logic [7:0]         last_instr_d, last_instr_q;

  regfile_core u_core (
    .clk       (clk),
    .rst       (rst),
    .we        (WB_regwrite),
    .waddr     (WB_writereg),
    .wdata     (wb_wdata),
    .raddr1    (rd_addr1),
    .raddr2    (rd_addr2),
    .dbg_addr  (dbg_addr),
    .rdata1    (core_rdata1_s),
    .rdata2    (core_rdata2_s),
    .dbg_rdata (dbg_data)
  );

  // Write-back value select; independent of the write enable.
  always_comb begin
    if (WB_ImmLoad) begin
      wb_wdata = WB_ImmData;
    end else begin
      wb_wdata = WB_ALUres;
    end
  end

  // Decode read ports: a same-cycle write to the addressed register is
  // forwarded so decode never sees the stale value.
  always_comb begin
    if (WB_regwrite && (rd_addr1 == WB_writereg)) begin
      rd_data1 = wb_wdata;
    end else begin
      rd_data1 = core_rdata1_s;
    end
    if (WB_regwrite && (rd_addr2 == WB_writereg)) begin
      rd_data2 = wb_wdata;
    end else begin
      rd_data2 = core_rdata2_s;
    end
  end

  // Retire tracking: any non-bubble retires, whether or not it writes.
  // The counter wraps silently.
  always_comb begin
    retire_s        = (WB_instr != NOP_INSTR);
    retired_count_d = retired_count_q;
    last_instr_d    = last_instr_q;
    if (rst) begin
      retired_count_d = '0;
      last_instr_d    = 8'h00;
    end else if (retire_s) begin
      retired_count_d = retired_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      last_instr_d    = WB_instr;
    end else begin
      retired_count_d = retired_count_q;
      last_instr_d    = last_instr_q;
    end
  end

  // Retire state flops.
  always_ff @(posedge clk) begin
    retired_count_q <= retired_count_d;
    last_instr_q    <= last_instr_d;
  end

  assign retired_count = retired_count_q;
  assign last_instr    = last_instr_q;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile -- directed and randomized bench for wb_regfile with an
// array-based reference model of the register file and retire counter.
module tb_wb_regfile;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       WB_regwrite, WB_ImmLoad;
  logic [7:0] WB_ALUres, WB_ImmData;
  logic [2:0] WB_writereg;
  logic [7:0] WB_instr;
  logic [2:0] rd_addr1, rd_addr2, dbg_addr;
  logic [7:0] rd_data1, rd_data2, dbg_data, wb_wdata;
  logic [15:0] retired_count;
  logic [7:0] last_instr;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  m_regs [8];
  logic [15:0] m_cnt;
  logic [7:0]  m_last;

  always #5 clk = ~clk;

  wb_regfile #(.CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .WB_regwrite   (WB_regwrite),
    .WB_ImmLoad    (WB_ImmLoad),
    .WB_ALUres     (WB_ALUres),
    .WB_ImmData    (WB_ImmData),
    .WB_writereg   (WB_writereg),
    .WB_instr      (WB_instr),
    .rd_addr1      (rd_addr1),
    .rd_addr2      (rd_addr2),
    .rd_data1      (rd_data1),
    .rd_data2      (rd_data2),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data),
    .wb_wdata      (wb_wdata),
    .retired_count (retired_count),
    .last_instr    (last_instr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Combinational outputs against the model, sampled mid-cycle.
  task automatic comb_check();
    logic [7:0] exp_w;
    exp_w = WB_ImmLoad ? WB_ImmData : WB_ALUres;
    chk("wb_wdata", {24'd0, wb_wdata}, {24'd0, exp_w});
    if (!rst) begin
      chk("rd_data1", {24'd0, rd_data1},
          {24'd0, (WB_regwrite && rd_addr1 == WB_writereg) ? exp_w : m_regs[rd_addr1]});
      chk("rd_data2", {24'd0, rd_data2},
          {24'd0, (WB_regwrite && rd_addr2 == WB_writereg) ? exp_w : m_regs[rd_addr2]});
    end
    chk("dbg_pre", {24'd0, dbg_data}, {24'd0, m_regs[dbg_addr]});
  endtask

  // One clock: advance the model at the edge, check state on the negedge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_cnt  = 16'h0000;
      m_last = 8'h00;
    end else begin
      if (WB_regwrite) m_regs[WB_writereg] = WB_ImmLoad ? WB_ImmData : WB_ALUres;
      if (WB_instr != 8'h00) begin
        m_cnt  = m_cnt + 16'h0001;
        m_last = WB_instr;
      end
    end
    @(negedge clk);
    chk("retired_count", {16'd0, retired_count}, {16'd0, m_cnt});
    chk("last_instr", {24'd0, last_instr}, {24'd0, m_last});
    chk("dbg_post", {24'd0, dbg_data}, {24'd0, m_regs[dbg_addr]});
  endtask

  task automatic cycle();
    #1;
    comb_check();
    tick();
  endtask

  initial begin
    int unsigned n;
    logic [15:0] saved;

    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_cnt = 16'h0000; m_last = 8'h00;
    rst = 1'b1; WB_regwrite = 1'b0; WB_ImmLoad = 1'b0;
    WB_ALUres = 8'h00; WB_ImmData = 8'h00; WB_writereg = 3'd0;
    WB_instr = 8'h00; rd_addr1 = 3'd0; rd_addr2 = 3'd0; dbg_addr = 3'd0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Reset state on every register via the debug port.
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk("reset_reg", {24'd0, dbg_data}, 32'h0000_0000);
    end
    chk("reset_cnt", {16'd0, retired_count}, 32'h0000_0000);
    chk("reset_last", {24'd0, last_instr}, 32'h0000_0000);
    @(negedge clk);

    // ALU write with bypass on port 1; debug still shows the old value.
    WB_regwrite = 1'b1; WB_ImmLoad = 1'b0; WB_ALUres = 8'h5A;
    WB_writereg = 3'd3; WB_instr = 8'h23; rd_addr1 = 3'd3; dbg_addr = 3'd3;
    #1;
    chk("alu_bypass", {24'd0, rd_data1}, 32'h0000_005A);
    chk("alu_dbg_old", {24'd0, dbg_data}, 32'h0000_0000);
    tick();
    chk("alu_dbg_new", {24'd0, dbg_data}, 32'h0000_005A);
    chk("alu_cnt", {16'd0, retired_count}, 32'h0000_0001);
    chk("alu_last", {24'd0, last_instr}, 32'h0000_0023);

    // Immediate load, then the same inputs without write enable.
    WB_ImmLoad = 1'b1; WB_ImmData = 8'hC3; WB_ALUres = 8'hFF;
    WB_writereg = 3'd7; WB_instr = 8'h45; dbg_addr = 3'd7;
    #1;
    chk("imm_wdata", {24'd0, wb_wdata}, 32'h0000_00C3);
    tick();
    chk("imm_reg7", {24'd0, dbg_data}, 32'h0000_00C3);
    WB_regwrite = 1'b0; WB_ImmData = 8'h3C;
    cycle();
    chk("imm_nowrite", {24'd0, dbg_data}, 32'h0000_00C3);

    // Dual bypass, back-to-back writes to the same register.
    WB_regwrite = 1'b1; WB_ImmLoad = 1'b0; WB_ALUres = 8'h11;
    WB_writereg = 3'd2; rd_addr1 = 3'd2; rd_addr2 = 3'd2; dbg_addr = 3'd2;
    #1;
    chk("b2b_p1_a", {24'd0, rd_data1}, 32'h0000_0011);
    chk("b2b_p2_a", {24'd0, rd_data2}, 32'h0000_0011);
    tick();
    WB_ALUres = 8'h22;
    #1;
    chk("b2b_p1_b", {24'd0, rd_data1}, 32'h0000_0022);
    chk("b2b_p2_b", {24'd0, rd_data2}, 32'h0000_0022);
    tick();
    chk("b2b_final", {24'd0, dbg_data}, 32'h0000_0022);

    // NOPs do not retire.
    WB_regwrite = 1'b0; WB_instr = 8'h00;
    saved = m_cnt;
    cycle(); cycle(); cycle();
    chk("nop_cnt", {16'd0, retired_count}, {16'd0, saved});

    // Run the counter up to all-ones, then one more retire wraps to zero.
    WB_instr = 8'h01;
    n = 32'(16'hFFFF - m_cnt);
    repeat (n) @(negedge clk);
    m_cnt = 16'hFFFF; m_last = 8'h01;
    chk("pre_wrap", {16'd0, retired_count}, 32'h0000_FFFF);
    WB_instr = 8'h9C;
    cycle();
    chk("wrap_cnt", {16'd0, retired_count}, 32'h0000_0000);
    chk("wrap_last", {24'd0, last_instr}, 32'h0000_009C);

    // Randomized traffic against the model, with occasional resets.
    for (int k = 0; k < 300; k++) begin
      rst         = ($urandom_range(0, 31) == 0);
      WB_regwrite = 1'($urandom);
      WB_ImmLoad  = 1'($urandom);
      WB_ALUres   = 8'($urandom);
      WB_ImmData  = 8'($urandom);
      WB_writereg = 3'($urandom);
      WB_instr    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rd_addr1    = 3'($urandom);
      rd_addr2    = ($urandom_range(0, 3) == 0) ? WB_writereg : 3'($urandom);
      dbg_addr    = 3'($urandom);
      cycle();
    end
    rst = 1'b0;

    // Reset wins over a write in the same cycle.
    WB_instr = 8'h07; WB_regwrite = 1'b1; WB_ImmLoad = 1'b0;
    WB_ALUres = 8'h55; WB_writereg = 3'd4;
    tick();
    rst = 1'b1; WB_ALUres = 8'hAA; WB_instr = 8'h12; dbg_addr = 3'd4;
    tick();
    rst = 1'b0; WB_regwrite = 1'b0; WB_instr = 8'h00;
    #1;
    chk("rst_mid_reg4", {24'd0, dbg_data}, 32'h0000_0000);
    chk("rst_mid_cnt", {16'd0, retired_count}, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_wb_regfile

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the EX/WB pipeline register: the writeback stage plus the architectural register file of the 8-bit pipelined CPU.
- Takes the WB-stage control and data, selects the write-back value (ALU result or immediate), and commits it to an 8 x 8-bit register file.
- Serves two decode-stage read ports, with same-cycle WB-to-read bypass, and one debug read port.
- Counts retired instructions and holds the last retired instruction for trace/debug.

Parameters:
- DATA_W, 8, register and datapath width
- ADDR_W, 3, register address width; register count = 2**ADDR_W
- CNT_W, 16, retired-instruction counter width
- NOP_INSTR, 8'h00, bubble encoding; not counted as retired

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- WB_regwrite  input  1  write-enable from EX/WB register
- WB_ImmLoad  input  1  1 = write WB_ImmData, 0 = write WB_ALUres
- WB_ALUres  input  DATA_W  ALU result
- WB_ImmData  input  DATA_W  immediate data
- WB_writereg  input  ADDR_W  destination register
- WB_instr  input  8  instruction in WB stage
- rd_addr1  input  ADDR_W  decode read port 1 address
- rd_addr2  input  ADDR_W  decode read port 2 address
- rd_data1  output  DATA_W  read port 1 data (bypassed)
- rd_data2  output  DATA_W  read port 2 data (bypassed)
- dbg_addr  input  ADDR_W  debug read address
- dbg_data  output  DATA_W  debug read data (architectural, no bypass)
- wb_wdata  output  DATA_W  selected write-back value (combinational)
- retired_count  output  CNT_W  retired-instruction counter
- last_instr  output  8  last non-NOP instruction retired

Behaviour:
- Reset: on a rising clk edge with rst=1, all registers, retired_count and last_instr go to 0. rst=1 overrides any write in that cycle.
- wb_wdata = WB_ImmLoad ? WB_ImmData : WB_ALUres. Purely combinational, independent of WB_regwrite.
- Write:
  - On a rising edge with rst=0 and WB_regwrite=1, reg[WB_writereg] <= wb_wdata.
  - All registers are writable; there is no hardwired zero register.
  - WB_ImmLoad=1 with WB_regwrite=0 writes nothing.
- Read ports: combinational, zero latency.
  - If WB_regwrite=1 and rd_addrN == WB_writereg, rd_dataN = wb_wdata (bypass). Otherwise rd_dataN = reg[rd_addrN].
  - Both ports may hit the bypass simultaneously and then both return wb_wdata.
  - The bypass is also active while rst=1. Decode output is don't-care during reset.
- Debug port: dbg_data = reg[dbg_addr]. It never bypasses, so it shows a new value only from the cycle after the write edge.
- Retire:
  - On a rising edge with rst=0 and WB_instr != NOP_INSTR: retired_count <= retired_count + 1, and last_instr <= WB_instr.
  - Retirement counts independently of WB_regwrite; stores and branches also retire.
- Counter width: modulo 2**CNT_W, wraps from all-ones to 0 with no flag.
- Back-to-back writes to the same register: each cycle's bypass returns that cycle's wb_wdata. The register holds the latest value after the edge.
- No internal FSM beyond the register state. Every output is a function of current inputs and registered state.

Decomposition:
- Shared package cpu_pkg: DATA_W, ADDR_W, NOP_INSTR, and the register-address type (logic [ADDR_W-1:0]). The ID stage and EX/WB register also use these.
- One sub-module, regfile_core: 2**ADDR_W x DATA_W storage with one synchronous-reset write port and three combinational read ports (rd1, rd2, dbg).
- Bypass muxes, wb_wdata select and the retire counter live in wb_regfile.

Test Plan:
- Reset then idle: assert rst for 2 cycles, then read all 8 registers on dbg -> every value 8'h00, retired_count=0, last_instr=8'h00.
- ALU write: WB_regwrite=1, WB_ImmLoad=0, WB_ALUres=8'h5A, WB_writereg=3, WB_instr=8'h23, rd_addr1=3.
  - Same cycle: rd_data1=8'h5A (bypass), dbg_data at dbg_addr=3 = 8'h00.
  - After the edge: dbg_data=8'h5A, retired_count=1, last_instr=8'h23.
- Immediate load: WB_ImmLoad=1, WB_ImmData=8'hC3, WB_ALUres=8'hFF, WB_writereg=7 -> wb_wdata=8'hC3, reg7=8'hC3. With WB_regwrite=0 the same inputs leave reg7 unchanged.
- Dual bypass and back-to-back: write reg2=8'h11 then reg2=8'h22 on consecutive cycles with rd_addr1=rd_addr2=2 -> both ports show 8'h11 then 8'h22. Final reg2=8'h22.
- NOP and wrap:
  - WB_instr=8'h00 for 3 cycles -> retired_count unchanged.
  - Preload the counter to 16'hFFFF via 65535 non-NOP retires, then one more retire -> retired_count=16'h0000.
- Reset mid-write: rst=1 in the same cycle as WB_regwrite=1, WB_writereg=4, data 8'hAA -> after the edge reg4=8'h00, retired_count=0.
